mac_sequencer: RTL and testbench

Control and operand-feed stage directly upstream of the MAC unit. It holds one layer's input vector, weight matrix and per-neuron biases in local register files. On `start` it drives the MAC's `rst_Acc`/`ld_Acc`/`cur_input`/`cur_weight`/`cur_bios` to evaluate every neuron in turn, and captures each MAC `result` into a one-cycle output stream. The block performs no arithmetic: all data words are 8-bit sign-magnitude (bit 7 = sign) and pass through unchanged.

---
 rtl/nn_pkg.sv | 24 ++
 rtl/nn_regfile.sv | 26 ++
 rtl/mac_sequencer.sv | 147 ++++++++++++++
 tb/tb_mac_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the layer sequencer: FSM states, register-file
// select codes, word format constants and an address-width helper.
package nn_pkg;

    localparam int SIGN_BIT   = 7;
    localparam int DW_DEFAULT = SIGN_BIT + 1;

    localparam logic [1:0] SEL_INPUT  = 2'd0;
    localparam logic [1:0] SEL_WEIGHT = 2'd1;
    localparam logic [1:0] SEL_BIAS   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_ACC,
        S_CAP
    } state_t;

    // Address width that never collapses to zero bits for single-entry arrays.
    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/nn_regfile.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module nn_regfile #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/mac_sequencer.sv
// Operand feed and control for the MAC unit: walks every neuron of a layer
// (clear, N_INPUTS accumulates, capture) and streams each captured result.
module mac_sequencer
    import nn_pkg::*;
#(
    parameter int N_INPUTS  = 4,
    parameter int N_NEURONS = 3,
    parameter int DW        = DW_DEFAULT,
    localparam int AW       = addr_w(N_INPUTS * N_NEURONS),
    localparam int NW       = addr_w(N_NEURONS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [1:0]    wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rst_Acc,
    output logic          ld_Acc,
    output logic [DW-1:0] cur_input,
    output logic [DW-1:0] cur_weight,
    output logic [DW-1:0] cur_bios,
    input  logic [DW-1:0] mac_result,
    output logic          out_valid,
    output logic [NW-1:0] out_idx,
    output logic [DW-1:0] out_data
);

    localparam int KW = addr_w(N_INPUTS);

    state_t        state;
    state_t        state_next;
    logic [NW-1:0] n;
    logic [KW-1:0] k;

    logic          in_we;
    logic          w_we;
    logic          b_we;
    logic [AW-1:0] w_raddr;
    logic [DW-1:0] in_rd;
    logic [DW-1:0] w_rd;
    logic [DW-1:0] b_rd;
    logic          k_last;
    logic          n_last;

    assign busy   = (state != S_IDLE);
    assign k_last = (k == KW'(N_INPUTS - 1));
    assign n_last = (n == NW'(N_NEURONS - 1));

    // Loads are frozen for the whole run so operands stay coherent.
    assign in_we = wr_en && !busy && (wr_sel == SEL_INPUT)  && (32'(wr_addr) < N_INPUTS);
    assign w_we  = wr_en && !busy && (wr_sel == SEL_WEIGHT) && (32'(wr_addr) < N_INPUTS * N_NEURONS);
    assign b_we  = wr_en && !busy && (wr_sel == SEL_BIAS)   && (32'(wr_addr) < N_NEURONS);

    assign w_raddr = AW'(32'(n) * 32'(N_INPUTS) + 32'(k));

    nn_regfile #(.DEPTH(N_INPUTS), .DW(DW), .AW(KW)) u_inputs (
        .clk   (clk),
        .we    (in_we),
        .waddr (wr_addr[KW-1:0]),
        .wdata (wr_data),
        .raddr (k),
        .rdata (in_rd)
    );

    nn_regfile #(.DEPTH(N_INPUTS * N_NEURONS), .DW(DW), .AW(AW)) u_weights (
        .clk   (clk),
        .we    (w_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (w_raddr),
        .rdata (w_rd)
    );

    nn_regfile #(.DEPTH(N_NEURONS), .DW(DW), .AW(NW)) u_biases (
        .clk   (clk),
        .we    (b_we),
        .waddr (wr_addr[NW-1:0]),
        .wdata (wr_data),
        .raddr (n),
        .rdata (b_rd)
    );

    always_comb begin
        state_next = state;
        rst_Acc    = 1'b0;
        ld_Acc     = 1'b0;
        cur_input  = '0;
        cur_weight = '0;
        cur_bios   = '0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_CLR;
            end
            S_CLR: begin
                rst_Acc    = 1'b1;
                state_next = S_ACC;
            end
            S_ACC: begin
                ld_Acc     = 1'b1;
                cur_input  = in_rd;
                cur_weight = w_rd;
                cur_bios   = b_rd;
                if (k_last) state_next = S_CAP;
            end
            S_CAP: begin
                cur_bios   = b_rd;
                state_next = n_last ? S_IDLE : S_CLR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            n         <= '0;
            k         <= '0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_next;
            done      <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                S_IDLE: if (start) n <= '0;
                S_CLR:  k <= '0;
                S_ACC:  if (!k_last) k <= k + KW'(1);
                S_CAP: begin
                    // The MAC result is only guaranteed stable during CAP.
                    out_valid <= 1'b1;
                    out_idx   <= n;
                    out_data  <= mac_result;
                    if (n_last) done <= 1'b1;
                    else        n    <= n + NW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with a sign-magnitude MAC stub and a cycle-offset
// reference model of the layer schedule.
module tb_mac_sequencer;
    import nn_pkg::*;

    localparam int NI = 3;
    localparam int NN = 2;
    localparam int L  = NN * (NI + 2);
    localparam int AW = addr_w(NI * NN);
    localparam int OW = addr_w(NN);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [1:0]    wr_sel;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          start;
    logic          busy, done, rst_Acc, ld_Acc, out_valid;
    logic [7:0]    cur_input, cur_weight, cur_bios, mac_result, out_data;
    logic [OW-1:0] out_idx;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mac_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rst_Acc    (rst_Acc),
        .ld_Acc     (ld_Acc),
        .cur_input  (cur_input),
        .cur_weight (cur_weight),
        .cur_bios   (cur_bios),
        .mac_result (mac_result),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_data   (out_data)
    );

    function automatic int from_sm(input logic [7:0] v);
        int m;
        m = int'(v[6:0]);
        return v[7] ? -m : m;
    endfunction

    function automatic logic [7:0] to_sm(input int v);
        int m;
        m = (v < 0) ? -v : v;
        if (m > 127) m = 127;
        return {(v < 0), 7'(m)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // MAC stub: accumulate in[k]*w[k], result = acc + bias, all sign-magnitude.
    int acc = 0;
    always @(posedge clk) begin
        if (rst_Acc)     acc <= 0;
        else if (ld_Acc) acc <= acc + from_sm(cur_input) * from_sm(cur_weight);
    end
    always_comb mac_result = to_sm(acc + from_sm(cur_bios));

    // Reference model: mirrored contents plus position within the current run.
    logic [7:0] m_in [NI];
    logic [7:0] m_w  [NI*NN];
    logic [7:0] m_b  [NN];
    int         runpos = 0;
    logic       e_valid = 1'b0;
    logic       e_done  = 1'b0;
    int         e_idx   = 0;
    logic [7:0] e_data  = 8'h00;

    function automatic logic [7:0] neuron_sm(input int nn);
        int s;
        s = from_sm(m_b[nn]);
        for (int i = 0; i < NI; i++) s += from_sm(m_in[i]) * from_sm(m_w[nn*NI+i]);
        return to_sm(s);
    endfunction

    initial begin
        for (int i = 0; i < NI; i++)    m_in[i] = 8'h00;
        for (int i = 0; i < NI*NN; i++) m_w[i]  = 8'h00;
        for (int i = 0; i < NN; i++)    m_b[i]  = 8'h00;
    end

    always @(posedge clk) begin
        if (runpos == 0 && wr_en) begin
            if (wr_sel == 2'd0 && int'(wr_addr) < NI)    m_in[int'(wr_addr)] <= wr_data;
            if (wr_sel == 2'd1 && int'(wr_addr) < NI*NN) m_w[int'(wr_addr)]  <= wr_data;
            if (wr_sel == 2'd2 && int'(wr_addr) < NN)    m_b[int'(wr_addr)]  <= wr_data;
        end
        if (!rst) begin
            runpos  <= 0;
            e_valid <= 1'b0;
            e_done  <= 1'b0;
            e_idx   <= 0;
            e_data  <= 8'h00;
        end else begin
            e_valid <= 1'b0;
            e_done  <= 1'b0;
            if (runpos > 0 && runpos % (NI + 2) == 0) begin
                e_valid <= 1'b1;
                e_idx   <= runpos / (NI + 2) - 1;
                e_data  <= neuron_sm(runpos / (NI + 2) - 1);
                e_done  <= (runpos == L);
            end
            if (runpos > 0 && runpos < L)    runpos <= runpos + 1;
            else if (runpos == 0 && start)   runpos <= 1;
            else                             runpos <= 0;
        end
    end

    always @(negedge clk) begin
        logic       eb, e_rst, e_ld;
        int         p, nn;
        logic [7:0] e_in, e_w, e_b;
        eb    = (runpos >= 1 && runpos <= L);
        e_rst = 1'b0; e_ld = 1'b0;
        e_in  = 8'h00; e_w = 8'h00; e_b = 8'h00;
        if (eb) begin
            p  = (runpos - 1) % (NI + 2);
            nn = (runpos - 1) / (NI + 2);
            e_rst = (p == 0);
            e_ld  = (p >= 1 && p <= NI);
            if (e_ld) begin
                e_in = m_in[p-1];
                e_w  = m_w[nn*NI + p - 1];
            end
            if (p != 0) e_b = m_b[nn];
        end
        chk("busy", int'(busy), int'(eb));
        chk("rst_Acc", int'(rst_Acc), int'(e_rst));
        chk("ld_Acc", int'(ld_Acc), int'(e_ld));
        chk("cur_input", int'(cur_input), int'(e_in));
        chk("cur_weight", int'(cur_weight), int'(e_w));
        chk("cur_bios", int'(cur_bios), int'(e_b));
        chk("out_valid", int'(out_valid), int'(e_valid));
        chk("done", int'(done), int'(e_done));
        chk("out_idx", int'(out_idx), e_idx);
        chk("out_data", int'(out_data), int'(e_data));
    end

    task automatic wr(input logic [1:0] sel, input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rst_Acc"}, int'(rst_Acc), 0);
        chk({tag, "_ld_Acc"}, int'(ld_Acc), 0);
        chk({tag, "_cur_in"}, int'(cur_input), 0);
        chk({tag, "_cur_w"}, int'(cur_weight), 0);
        chk({tag, "_cur_b"}, int'(cur_bios), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_idx"}, int'(out_idx), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
    endtask

    // Runs one layer from a start pulse and checks literal timing and results.
    task automatic run_literal(input string tag, input bit restart_on_done);
        int vc0, vc1, bcnt;
        logic [7:0] d0, d1;
        vc0 = -1; vc1 = -1; bcnt = 0; d0 = 8'h00; d1 = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            if (j <= 11 && busy) bcnt++;
            if (out_valid && vc0 < 0) begin vc0 = j; d0 = out_data; end
            else if (out_valid && vc1 < 0) begin vc1 = j; d1 = out_data; end
            if (j == 11) chk({tag, "_done_c11"}, int'(done), 1);
            if (j == 12 && restart_on_done) chk({tag, "_clr_after_done"}, int'(rst_Acc), 1);
            start = (j == 11 && restart_on_done);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_valid0_cycle"}, vc0, NI + 3);
        chk({tag, "_valid1_cycle"}, vc1, 2 * (NI + 2) + 1);
        chk({tag, "_data0"}, int'(d0), 8'h94);
        chk({tag, "_data1"}, int'(d1), 8'h08);
        chk({tag, "_busy_cycles"}, bcnt, L);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_sel = 2'd0; wr_addr = '0; wr_data = 8'h00; start = 1'b0;
        repeat (3) @(negedge clk);
        all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        wr(SEL_INPUT, 0, 8'd3);  wr(SEL_INPUT, 1, 8'd3);  wr(SEL_INPUT, 2, 8'd2);
        wr(SEL_WEIGHT, 0, 8'd3); wr(SEL_WEIGHT, 1, 8'b10000110); wr(SEL_WEIGHT, 2, 8'b10001000);
        wr(SEL_WEIGHT, 3, 8'd1); wr(SEL_WEIGHT, 4, 8'd1); wr(SEL_WEIGHT, 5, 8'd1);
        wr(SEL_BIAS, 0, 8'd5);   wr(SEL_BIAS, 1, 8'd0);
        wr(2'd3, 0, 8'h55);      wr(SEL_WEIGHT, 7, 8'h66);  wr(SEL_BIAS, 3, 8'h77);
        @(negedge clk);
        chk("model_neuron0", int'(neuron_sm(0)), 8'h94);
        chk("model_neuron1", int'(neuron_sm(1)), 8'h08);

        // Back-to-back runs: start accepted in the done cycle.
        run_literal("run1", 1'b1);
        repeat (12) @(negedge clk);

        // start and writes while busy must be ignored.
        start = 1'b1;
        @(negedge clk);                    // cycle 1
        start = 1'b0;
        @(negedge clk);                    // cycle 2, first ACC
        chk("first_weight", int'(cur_weight), 8'h03);
        @(negedge clk);                    // cycle 3
        start = 1'b1; wr_en = 1'b1; wr_sel = SEL_WEIGHT; wr_addr = '0; wr_data = 8'h7f;
        @(negedge clk);                    // cycle 4
        start = 1'b0; wr_sel = SEL_BIAS; wr_data = 8'h11;
        @(negedge clk);                    // cycle 5
        wr_en = 1'b0;
        repeat (6) @(negedge clk);         // cycle 11
        chk("busy_run_done", int'(done), 1);
        @(negedge clk);
        chk("no_restart", int'(busy), 0);
        run_literal("after_busy_writes", 1'b0);

        // Reset in neuron 1's first ACC cycle aborts without done.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);         // cycle 7
        rst = 1'b0;
        @(negedge clk);                    // cycle 8
        rst = 1'b1;
        all_zero("abort");
        repeat (3) @(negedge clk);
        run_literal("after_abort", 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_sel  = 2'($urandom_range(0, 3));
            wr_addr = AW'($urandom_range(0, (1 << AW) - 1));
            wr_data = 8'($urandom);
            start   = ($urandom_range(0, 9) == 0);
            rst     = ($urandom_range(0, 99) != 0);
            @(negedge clk);
        end
        wr_en = 1'b0; start = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
